// File: rtl/mem_io_sequencer.sv
// Load/store sequencer: decodes a core data request into a single-cycle
// BRAM access or a handshaked peripheral access with timeout, freezing the
// core until a one-cycle completion pulse is produced.
module mem_io_sequencer #(
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [9:0]  io_addr,
  output logic [31:0] io_wdata,
  input  logic        io_ack,
  input  logic [31:0] io_rdata
);

  localparam int unsigned CW = $clog2(IO_TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_IO, S_RESP} state_t;

  state_t        state, state_nx;
  logic [13:0]   word_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          we_q;
  logic          err_q;
  logic          from_mem_q;
  logic [CW-1:0] cnt_q;

  logic is_io, misaligned, timeout;

  assign is_io      = (req_addr[31:10] == 22'h3FFFFF);
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign timeout    = (cnt_q == CW'(IO_TIMEOUT - 1));

  // Only the word address is latched: misaligned requests never reach
  // MEM or IO, so the IO byte address always has zero low bits.
  assign mem_addr  = word_q;
  assign mem_wdata = wdata_q;
  assign io_addr   = {word_q[7:0], 2'b00};
  assign io_wdata  = wdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (misaligned) state_nx = S_RESP;
          else if (is_io) state_nx = S_IO;
          else            state_nx = S_MEM;
        end
      end
      S_MEM:  state_nx = S_RESP;
      S_IO:   if (io_ack || timeout) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latches, IO wait counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      from_mem_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            word_q     <= req_addr[15:2];
            wdata_q    <= req_wdata;
            we_q       <= req_we;
            rdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= misaligned;
            from_mem_q <= !misaligned && !is_io;
          end
        end
        S_IO: begin
          cnt_q <= cnt_q + 1'b1;
          if (io_ack) begin
            rdata_q <= we_q ? '0 : io_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; stall is held low while reset is asserted
  always_comb begin
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    io_req    = 1'b0;
    io_we     = 1'b0;
    case (state)
      S_IDLE: stall = rst_n && req_valid;
      S_MEM: begin
        stall  = rst_n;
        mem_en = 1'b1;
        mem_we = we_q;
      end
      S_IO: begin
        stall  = rst_n;
        io_req = 1'b1;
        io_we  = we_q;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = from_mem_q ? (we_q ? '0 : mem_rdata) : rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Directed bench for mem_io_sequencer: a behavioural BRAM, an IO responder
// driven per step, and a response scoreboard checked on rsp_valid.
module tb_mem_io_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        io_req, io_we;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t sb[$];

  mem_io_sequencer #(.IO_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bram_word(input logic [13:0] a);
    return (a == 14'd4) ? 32'hDEADBEEF : ({18'h0, a} ^ 32'hA5A50000);
  endfunction

  // Registered BRAM read port
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mem_rdata <= 32'h0;
    else if (mem_en) mem_rdata <= bram_word(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_err}, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_mem"}, {mem_en, mem_we, mem_addr}, 0);
    chk({tag, "_mwd"}, mem_wdata, 0);
    chk({tag, "_io"}, {io_req, io_we, io_addr}, 0);
    chk({tag, "_iwd"}, io_wdata, 0);
  endtask

  // One complete transaction; ack_after = IO cycle index carrying io_ack (0 = never)
  task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                     input logic [31:0] wdata, input int ack_after, input logic [31:0] ack_rdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_io, input int exp_mem);
    int n, io_n, mem_n;
    bit seen;
    rsp_t e;
    cyc();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    chk({tag, "_stall_T"}, stall, 1);
    chk({tag, "_rsp_T"}, rsp_valid, 0);
    n = 0; io_n = 0; mem_n = 0; seen = 0;
    while (!seen && n < 40) begin
      cyc();
      n++;
      io_ack   = (n == ack_after);
      io_rdata = (n == ack_after) ? ack_rdata : 32'h0BAD0BAD;
      @(negedge clk);
      chk({tag, "_excl"}, {31'h0, mem_en & io_req}, 0);
      if (mem_en) begin
        mem_n++;
        chk({tag, "_mem_addr"}, {18'h0, mem_addr}, {18'h0, addr[15:2]});
        chk({tag, "_mem_we"}, mem_we, we);
        if (we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
      end else chk({tag, "_mem_we_off"}, mem_we, 0);
      if (io_req) begin
        io_n++;
        chk({tag, "_io_addr"}, {22'h0, io_addr}, {22'h0, addr[9:0]});
        chk({tag, "_io_we"}, io_we, we);
        chk({tag, "_io_wdata"}, io_wdata, wdata);
      end else chk({tag, "_io_we_off"}, io_we, 0);
      if (rsp_valid) begin
        seen = 1;
        chk({tag, "_stall_resp"}, stall, 0);
        chk({tag, "_latency"}, n, exp_lat);
        if (sb.size() == 0) chk({tag, "_unexpected_rsp"}, 1, 0);
        else begin
          e = sb.pop_front();
          chk({tag, "_rdata"}, rsp_rdata, e.rdata);
          chk({tag, "_err"}, rsp_err, e.err);
        end
      end else chk({tag, "_stall_busy"}, stall, 1);
    end
    if (!seen) chk({tag, "_rsp_timeout"}, 0, 1);
    chk({tag, "_io_cycles"}, io_n, exp_io);
    chk({tag, "_mem_cycles"}, mem_n, exp_mem);
    cyc();
    req_valid = 1'b0; io_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_rsp"}, rsp_valid, 0);
    chk({tag, "_idle_stall"}, stall, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    io_ack = 1'b0; io_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("in_reset");
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Memory load, word 4
    txn("mem_load", 32'h0000_0010, 1'b0, 32'h0, 0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1);
    // Memory load, other word
    txn("mem_load2", 32'h0000_0A4C, 1'b0, 32'h0, 0, 32'h0, bram_word(14'h293), 1'b0, 2, 0, 1);
    // Memory store returns zero data
    txn("mem_store", 32'h0000_0100, 1'b1, 32'hCAFEF00D, 0, 32'h0, 32'h0, 1'b0, 2, 0, 1);
    // IO store acked on third IO cycle
    txn("io_store", 32'hFFFF_FC60, 1'b1, 32'h0000_1234, 3, 32'h5555AAAA, 32'h0, 1'b0, 4, 3, 0);
    // IO load acked immediately
    txn("io_load", 32'hFFFF_FC04, 1'b0, 32'h0, 1, 32'h13579BDF, 32'h13579BDF, 1'b0, 2, 1, 0);
    // IO load with no ack times out
    txn("io_tmo", 32'hFFFF_FC70, 1'b0, 32'h0, 0, 32'h0, 32'h0, 1'b1, 16, 15, 0);
    // Ack coincident with the last allowed IO cycle wins
    txn("io_ack_last", 32'hFFFF_FC70, 1'b0, 32'h0, 15, 32'h0F1E2D3C, 32'h0F1E2D3C, 1'b0, 16, 15, 0);
    // Misaligned access errors without touching either port
    txn("misalign", 32'h0000_0006, 1'b0, 32'h0, 0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    // Address just below the IO window is memory
    txn("mem_edge", 32'hFFFF_FBFC, 1'b0, 32'h0, 0, 32'h0, bram_word(14'h3EFF), 1'b0, 2, 0, 1);

    // Stray ack while idle is ignored
    cyc();
    io_ack = 1'b1; io_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray_ack_ioreq", io_req, 0);
    cyc();
    io_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_rsp", rsp_valid, 0);

    // Reset mid-IO wait aborts silently
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hFFFF_FC70; req_wdata = '0;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    repeat (3) begin
      cyc();
      @(negedge clk);
      chk("rst_io_req_on", io_req, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_io_req_off", io_req, 0);
    chk("rst_stall_off", stall, 0);
    chk("rst_rsp", rsp_valid, 0);
    sb.delete();
    req_valid = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 0);
      cyc();
    end
    txn("after_rst", 32'h0000_0010, 1'b0, 32'h0, 0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
